// File: rtl/beat_rx_pkg.sv
// beat_rx_pkg: shared state type, default widths and nominal timeout for the beat receiver.
package beat_rx_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, LOCKED, STALLED} beat_state_t;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_PERIOD_W       = 32;
    localparam int DEF_BEAT_W         = 16;
    localparam int DEF_TIMEOUT_CYCLES = 12500000;
    localparam int DEF_GLITCH_CYCLES  = 4;
endpackage

// File: rtl/beat_tick_receiver_sync.sv
// sync_edge_detect: synchronises div_in and emits rise/fall pulses on accepted level changes.
// With BEAT_DEGLITCH_EN a new level must be stable GLITCH_CYCLES cycles before it is accepted.
module sync_edge_detect #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    if (SYNC_STAGES < 2 || GLITCH_CYCLES < 1) begin : g_chk
        $error("sync_edge_detect: SYNC_STAGES must be >= 2 and GLITCH_CYCLES >= 1");
    end
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   s;
    assign s = sync_q[SYNC_STAGES-1];
`ifdef BEAT_DEGLITCH_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic [GW-1:0] dcnt_q, dcnt_d;
    logic          rise_q, rise_d, fall_q, fall_d, accept;
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        accept  = (s != level_q) && (dcnt_q == GW'(GLITCH_CYCLES - 1));
        dcnt_d  = (s == level_q || accept) ? '0 : dcnt_q + 1'b1;
        level_d = accept ? s : level_q;
        rise_d  = accept & s;
        fall_d  = accept & ~s;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            dcnt_q  <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign rise = rise_q;
    assign fall = fall_q;
`else
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = s;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
        end
    end
    assign rise = s & ~level_q;
    assign fall = ~s & level_q;
`endif
endmodule

// File: rtl/beat_tick_receiver.sv
// beat_tick_receiver: turns the slow div_in toggle into clk-domain beat enables, beat count,
// period measurement and stall detection. Optional input deglitch via BEAT_DEGLITCH_EN.
module beat_tick_receiver
    import beat_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int PERIOD_W       = DEF_PERIOD_W,
    parameter int BEAT_W         = DEF_BEAT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GLITCH_CYCLES  = DEF_GLITCH_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                div_in,
    input  logic                clear,
    output logic                beat_tick,
    output logic                half_tick,
    output logic [BEAT_W-1:0]   beat_count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled
);
    logic rise, fall;
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_sync (
        .clk(clk), .rst_n(rst_n), .din(div_in), .rise(rise), .fall(fall)
    );
    beat_state_t         state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
    logic [BEAT_W-1:0]   bc_q, bc_d;
    logic                tick_q, tick_d, half_q, half_d, valid_q, valid_d, stalled_q, stalled_d;
    logic                timeout;
    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        timeout   = (cnt_q == PERIOD_W'(TIMEOUT_CYCLES - 1));
        tick_d    = rise & ~clear;
        half_d    = (rise | fall) & ~clear;
        bc_d      = clear ? '0 : bc_q + BEAT_W'(tick_d);
        cnt_d     = (clear || rise) ? '0 : cnt_inc;
        state_d   = state_q;
        period_d  = period_q;
        valid_d   = valid_q;
        stalled_d = stalled_q;
        if (clear) begin
            state_d   = IDLE;
            period_d  = '0;
            valid_d   = 1'b0;
            stalled_d = 1'b0;
        end else if (rise) begin
            // A period is only meaningful between two edges seen in ARMED/LOCKED.
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   begin state_d = LOCKED; period_d = cnt_inc; valid_d = 1'b1; end
                LOCKED:  period_d = cnt_inc;
                default: begin state_d = ARMED; stalled_d = 1'b0; end
            endcase
        end else if (timeout && (state_q == ARMED || state_q == LOCKED)) begin
            state_d   = STALLED;
            stalled_d = 1'b1;
            valid_d   = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            bc_q      <= '0;
            tick_q    <= 1'b0;
            half_q    <= 1'b0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            bc_q      <= bc_d;
            tick_q    <= tick_d;
            half_q    <= half_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end
    assign beat_tick    = tick_q;
    assign half_tick    = half_q;
    assign beat_count   = bc_q;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;
endmodule

// File: tb/tb_beat_tick_receiver.sv
// tb_beat_tick_receiver: directed vector table plus hand-written corner sequences.
module tb_beat_tick_receiver;
`ifdef BEAT_DEGLITCH_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, div_in = 1'b0, clear = 1'b0;
    logic        beat_tick, half_tick, period_valid, stalled;
    logic [3:0]  beat_count;
    logic [31:0] period;
    int          nvec = 0, errs = 0, hc = 0, tc = 0;

    beat_tick_receiver #(.SYNC_STAGES(2), .PERIOD_W(32), .BEAT_W(4), .TIMEOUT_CYCLES(100), .GLITCH_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .div_in(div_in), .clear(clear), .beat_tick(beat_tick),
        .half_tick(half_tick), .beat_count(beat_count), .period(period),
        .period_valid(period_valid), .stalled(stalled)
    );

    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (half_tick) hc++;
        if (beat_tick) tc++;
    end

    typedef struct {
        logic        div;
        int          w;
        logic        tick;
        logic        half;
        logic [3:0]  bc;
        logic [31:0] per;
        logic        vld;
        logic        stl;
    } vec_t;
    vec_t tv[16];

    function automatic vec_t mk(logic d, int w, logic t, logic h, logic [3:0] b, logic [31:0] p, logic v, logic s);
        vec_t r;
        r.div = d; r.w = w; r.tick = t; r.half = h; r.bc = b; r.per = p; r.vld = v; r.stl = s;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        div_in = 1'b0; clear = 1'b0; rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        int h0, t0;
        tv[0]  = mk(1, LAT,      1, 1, 1, 0,  0, 0);
        tv[1]  = mk(1, 20 - LAT, 0, 0, 1, 0,  0, 0);
        tv[2]  = mk(0, LAT,      0, 1, 1, 0,  0, 0);
        tv[3]  = mk(0, 20 - LAT, 0, 0, 1, 0,  0, 0);
        tv[4]  = mk(1, LAT,      1, 1, 2, 40, 1, 0);
        tv[5]  = mk(1, 20 - LAT, 0, 0, 2, 40, 1, 0);
        tv[6]  = mk(0, 20,       0, 0, 2, 40, 1, 0);
        tv[7]  = mk(1, LAT,      1, 1, 3, 40, 1, 0);
        tv[8]  = mk(1, 99,       0, 0, 3, 40, 1, 0);
        tv[9]  = mk(1, 1,        0, 0, 3, 40, 0, 1);
        tv[10] = mk(0, LAT,      0, 1, 3, 40, 0, 1);
        tv[11] = mk(0, 20 - LAT, 0, 0, 3, 40, 0, 1);
        tv[12] = mk(1, LAT,      1, 1, 4, 40, 0, 0);
        tv[13] = mk(1, 20 - LAT, 0, 0, 4, 40, 0, 0);
        tv[14] = mk(0, 20,       0, 0, 4, 40, 0, 0);
        tv[15] = mk(1, LAT,      1, 1, 5, 40, 1, 0);

        do_reset();
        chk("reset beat_tick", {31'd0, beat_tick}, 0);
        chk("reset beat_count", {28'd0, beat_count}, 0);
        chk("reset period", period, 0);
        chk("reset valid", {31'd0, period_valid}, 0);
        chk("reset stalled", {31'd0, stalled}, 0);

        for (int i = 0; i < 16; i++) begin
            div_in = tv[i].div;
            step(tv[i].w);
            chk($sformatf("v%0d beat_tick", i), {31'd0, beat_tick}, {31'd0, tv[i].tick});
            chk($sformatf("v%0d half_tick", i), {31'd0, half_tick}, {31'd0, tv[i].half});
            chk($sformatf("v%0d beat_count", i), {28'd0, beat_count}, {28'd0, tv[i].bc});
            chk($sformatf("v%0d period", i), period, tv[i].per);
            chk($sformatf("v%0d valid", i), {31'd0, period_valid}, {31'd0, tv[i].vld});
            chk($sformatf("v%0d stalled", i), {31'd0, stalled}, {31'd0, tv[i].stl});
        end

        // Beat counter wrap over 16 rises / 32 edges.
        do_reset();
        h0 = hc; t0 = tc;
        for (int i = 0; i < 32; i++) begin
            div_in = ~div_in;
            step(10);
            if (i == 28) chk("wrap bc at 15", {28'd0, beat_count}, 15);
        end
        step(10);
        chk("wrap bc to 0", {28'd0, beat_count}, 0);
        chk("wrap half count", hc - h0, 32);
        chk("wrap tick count", tc - t0, 16);

        // Clear coincident with an accepted rise.
        div_in = 1'b1;
        step(LAT - 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clear no tick", {31'd0, beat_tick}, 0);
        chk("clear bc", {28'd0, beat_count}, 0);
        chk("clear period", period, 0);
        chk("clear valid", {31'd0, period_valid}, 0);
        t0 = tc;
        step(10);
        chk("clear edge discarded", tc - t0, 0);
        div_in = 1'b0; step(20);
        div_in = 1'b1; step(LAT);
        chk("post-clear arm bc", {28'd0, beat_count}, 1);
        chk("post-clear arm valid", {31'd0, period_valid}, 0);
        step(20 - LAT); div_in = 1'b0; step(20);
        div_in = 1'b1; step(LAT);
        chk("post-clear lock valid", {31'd0, period_valid}, 1);
        chk("post-clear lock period", period, 40);

        // Async reset mid-period, off the clock edge.
        step(10);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst bc", {28'd0, beat_count}, 0);
        chk("async rst period", period, 0);
        chk("async rst valid", {31'd0, period_valid}, 0);
        step(2);
        div_in = 1'b0;
        rst_n = 1'b1;
        step(5);
        div_in = 1'b1; step(LAT);
        chk("after rst first rise bc", {28'd0, beat_count}, 1);
        chk("after rst first rise valid", {31'd0, period_valid}, 0);

`ifdef BEAT_DEGLITCH_EN
        do_reset();
        t0 = tc;
        div_in = 1'b1; step(2);
        div_in = 1'b0; step(12);
        chk("glitch ignored", tc - t0, 0);
        div_in = 1'b1; step(LAT - 1);
        chk("deglitch tick early", {31'd0, beat_tick}, 0);
        step(1);
        chk("deglitch tick at +7", {31'd0, beat_tick}, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
